// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester IDs, FSM encoding
// and the default data width.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    REQ_CPU  = 2'd0,
    REQ_LA   = 2'd1,
    REQ_SCAN = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational priority picker: the requester after 'last' in the ring
// CPU -> LA -> SCAN -> CPU wins; last = SCAN gives CPU > LA > SCAN.
module dmem_arb_prio
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    la_req,
  input  logic    scan_req,
  input  req_id_e last,
  output req_id_e winner
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = REQ_NONE;
    case (last)
      REQ_CPU: begin
        if      (la_req)   winner = REQ_LA;
        else if (scan_req) winner = REQ_SCAN;
        else if (cpu_req)  winner = REQ_CPU;
      end
      REQ_LA: begin
        if      (scan_req) winner = REQ_SCAN;
        else if (cpu_req)  winner = REQ_CPU;
        else if (la_req)   winner = REQ_LA;
      end
      default: begin
        if      (cpu_req)  winner = REQ_CPU;
        else if (la_req)   winner = REQ_LA;
        else if (scan_req) winner = REQ_SCAN;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Three-requester data-memory arbiter (CPU, logic analyzer, GPIO scanner).
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed CPU > LA > SCAN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              la_req,
  input  logic              la_we,
  input  logic [ADDR_W-1:0] la_addr,
  input  logic [DATA_W-1:0] la_wdata,
  output logic              la_ack,
  output logic [DATA_W-1:0] la_rdata,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_ack,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant_id
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  arb_state_e        state_q, state_d;
  req_id_e           grant_q, winner, rr_last;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, la_rdata_q, scan_rdata_q;
  logic [DATA_W-1:0] resp_data;
  logic              any_req, in_range;
  logic              resp_cpu, resp_la, resp_scan;

  assign any_req  = cpu_req | la_req | scan_req;
  assign in_range = {1'b0, lat_addr} < DEPTH_LIM;

  dmem_arb_prio u_prio (
    .cpu_req  (cpu_req),
    .la_req   (la_req),
    .scan_req (scan_req),
    .last     (rr_last),
    .winner   (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Last granted requester drops to lowest priority for the next arbitration.
  always_ff @(posedge clk) begin
    if (reset)
      rr_last <= REQ_SCAN;
    else if (state_q == ST_IDLE && any_req)
      rr_last <= winner;
  end
`else
  assign rr_last = REQ_SCAN;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Out-of-range accesses never touch memory and complete with zero data.
  assign mem_en    = (state_q == ST_ISSUE) && in_range;
  assign mem_we    = mem_en && lat_we && (grant_q != REQ_SCAN);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign resp_data = in_range ? mem_rdata : '0;

  assign resp_cpu  = (state_q == ST_RESP) && (grant_q == REQ_CPU);
  assign resp_la   = (state_q == ST_RESP) && (grant_q == REQ_LA);
  assign resp_scan = (state_q == ST_RESP) && (grant_q == REQ_SCAN);

  assign cpu_stall = cpu_req & ~resp_cpu;
  assign la_ack    = resp_la;
  assign scan_ack  = resp_scan;
  assign grant_id  = grant_q;

  // Read data is visible in the ack cycle, then held by the per-requester register.
  assign cpu_rdata  = resp_cpu  ? resp_data : cpu_rdata_q;
  assign la_rdata   = resp_la   ? resp_data : la_rdata_q;
  assign scan_rdata = resp_scan ? resp_data : scan_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_NONE;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cpu_rdata_q  <= '0;
      la_rdata_q   <= '0;
      scan_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            case (winner)
              REQ_CPU: begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
              end
              REQ_LA: begin
                lat_we    <= la_we;
                lat_addr  <= la_addr;
                lat_wdata <= la_wdata;
              end
              default: begin
                lat_we    <= 1'b0;
                lat_addr  <= scan_addr;
                lat_wdata <= '0;
              end
            endcase
          end
        end
        ST_RESP: begin
          grant_q <= REQ_NONE;
          case (grant_q)
            REQ_CPU:  cpu_rdata_q  <= resp_data;
            REQ_LA:   la_rdata_q   <= resp_data;
            REQ_SCAN: scan_rdata_q <= resp_data;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 10, meaning number of implemented memory words.
REQ-004 Ports SHALL be as follows, with reset reset, synchronous, active-high, and clock clk:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cpu_req  in  1  processor access request.
- cpu_we  in  1  processor write.
- cpu_addr  in  ADDR_W  processor word address.
- cpu_wdata  in  DATA_W  processor write data.
- cpu_rdata  out  DATA_W  processor read data.
- cpu_stall  out  1  processor stall.
- la_req  in  1  logic-analyzer debug request.
- la_we  in  1  logic-analyzer write.
- la_addr  in  ADDR_W  logic-analyzer address.
- la_wdata  in  DATA_W  logic-analyzer write data.
- la_ack  out  1  logic-analyzer completion pulse.
- la_rdata  out  DATA_W  logic-analyzer read data.
- scan_req  in  1  GPIO scanner read request.
- scan_addr  in  ADDR_W  scanner address.
- scan_ack  out  1  scanner completion pulse.
- scan_rdata  out  DATA_W  scanner read data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.
- grant_id  out  2  requester owning the current access; 3 = none.

Function
REQ-005 The FSM SHALL have three states, IDLE, ISSUE and RESP: IDLE goes to ISSUE when any request is pending, ISSUE always goes to RESP, and RESP always goes to IDLE.
REQ-006 In IDLE the arbiter SHALL register the winning requester; the winner's address, write enable and write data SHALL be latched at the same edge.
REQ-007 In ISSUE, mem_en=1, mem_we=latched we, and mem_addr/mem_wdata SHALL be driven from the latched values.
REQ-008 In RESP the arbiter SHALL capture mem_rdata into the winner's rdata register and pulse the winner's ack (CPU: stall low) for exactly one cycle.
REQ-009 Latency SHALL be: request sampled at edge t, mem_en high during cycle t+1, ack/rdata valid during cycle t+2, next grant no earlier than edge t+3.
REQ-010 cpu_stall SHALL equal cpu_req AND NOT (state==RESP AND grant_id==CPU).
REQ-011 Requesters SHALL hold request and payload until ack; a request dropped after grant SHALL NOT abort the access, and its ack still pulses.
REQ-012 Scanner requests SHALL never write: mem_we=0 whenever grant_id==SCAN.
REQ-013 For an address >= DEPTH, mem_en SHALL stay 0 in ISSUE, the returned rdata SHALL be 0, writes SHALL be dropped, and ack timing is unchanged.
REQ-014 rdata registers SHALL hold their value until the next access by the same requester.
REQ-015 Simultaneous requests SHALL be resolved per REQ-018; losers remain pending with no lost request.

Reset
REQ-016 On reset: state=IDLE, grant_id=3, mem_en=mem_we=0, all acks=0, all rdata=0, round-robin pointer=SCAN (so CPU is highest next).
REQ-017 A reset asserted in ISSUE or RESP SHALL abandon the access with no ack; a write presented in the same cycle as reset MAY complete in memory.

Configuration
REQ-018 With ARB_ROUND_ROBIN_EN defined, priority SHALL rotate, with the last granted requester lowest; without it, priority SHALL be fixed at CPU > LA > SCAN, and the pointer logic is absent.

Structure
REQ-019 Package dmem_arb_pkg SHALL hold the requester IDs (CPU=0, LA=1, SCAN=2, NONE=3), the state encoding and the DATA_W default.
REQ-020 Sub-module dmem_arb_prio SHALL be combinational: three requests plus pointer in, winner ID out.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- CPU write addr 3 = 0xDEADBEEF, then CPU read addr 3 -> cpu_stall high 2 cycles each, cpu_rdata=0xDEADBEEF.
- CPU, LA and SCAN all requesting in one cycle, fixed priority -> grants CPU, LA, SCAN at edges t, t+3, t+6.
- Same stimulus with ARB_ROUND_ROBIN_EN and CPU re-requesting continuously -> LA and SCAN each granted within 9 cycles.
- LA read addr 12 (>= DEPTH) -> mem_en stays 0, la_ack pulses at t+2, la_rdata=0.
- SCAN request with scan_we-equivalent noise on la_we -> mem_we=0 throughout the scanner access.
- Reset asserted during ISSUE of a CPU read -> no ack, grant_id=3, cpu_stall high next cycle while cpu_req remains high.
